frame_buffer_writer: RTL

- Consumer at the far end of the rendering engine's output handshake (`ready` / `send_data` / `data` / `frame_ready`).
- Pulls one 32-bit iteration count per pixel and maps it to an 8-bit colour index.
- Writes the colour into a double-buffered frame memory through a request/acknowledge write port.
- Swaps banks at end of frame so the display side always reads a complete image.

---
 rtl/frame_buffer_writer_if.sv | 29 ++
 rtl/frame_buffer_writer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/frame_buffer_writer_if.sv
// Bundles the engine handshake, memory write port and frame status of the frame buffer writer.
// The writer connects through the slave modport; the engine/memory/display side uses master.
`timescale 1ns/1ps

interface frame_buffer_writer_if #(
   parameter int ADDR_W = 20
);
   logic              ready;
   logic [31:0]       data;
   logic              frame_ready;
   logic              send_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_ack;
   logic              display_bank;
   logic              frame_done;
   logic              frame_error;

   modport master (
      output ready, data, frame_ready, mem_ack,
      input  send_data, mem_we, mem_addr, mem_wdata, display_bank, frame_done, frame_error
   );

   modport slave (
      input  ready, data, frame_ready, mem_ack,
      output send_data, mem_we, mem_addr, mem_wdata, display_bank, frame_done, frame_error
   );
endinterface

// File: rtl/frame_buffer_writer.sv
// Pulls iteration counts from the rendering engine, maps them to colour indices and writes them
// into a double-buffered frame memory, swapping banks once a whole frame has been committed.
`timescale 1ns/1ps

module frame_buffer_writer #(
   parameter int X_SIZE   = 640,
   parameter int Y_SIZE   = 480,
   parameter int MAX_ITER = 255,
   parameter int ADDR_W   = 20
) (
   input logic                 clk,
   input logic                 rst_n,
   frame_buffer_writer_if.slave bus
);

   localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(X_SIZE * Y_SIZE);
   localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(X_SIZE * Y_SIZE - 1);
   localparam logic [31:0]       MAX_ITER_W = 32'(MAX_ITER);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      HOLD,
      WRITE
   } state_t;

   state_t            state_q, state_d;
   logic              bank_q, bank_d;
   logic [ADDR_W-1:0] pixel_idx_q, pixel_idx_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_error_q, frame_error_d;

   logic [7:0]        colour;
   logic [ADDR_W-1:0] pixel_addr;

   // Counts at or above MAX_ITER are inside the set (black); the rest map to 1..255.
   assign colour = (bus.data >= MAX_ITER_W) ? 8'h00 :
                   (bus.data > 32'd254)     ? 8'hFF :
                                              bus.data[7:0] + 8'd1;

   assign pixel_addr = bank_q ? (FRAME_PIX + pixel_idx_q) : pixel_idx_q;

   always_comb begin
      state_d       = state_q;
      bank_d        = bank_q;
      pixel_idx_d   = pixel_idx_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_we_d      = mem_we_q;
      frame_done_d  = 1'b0;
      frame_error_d = frame_error_q;

      case (state_q)
         IDLE: begin
            if (bus.ready) begin
               mem_wdata_d = colour;
               mem_addr_d  = pixel_addr;
               state_d     = CAPTURE;
            end else if (bus.frame_ready && (pixel_idx_q != '0)) begin
               // Short frame: flag it and restart the same bank from the top.
               frame_error_d = 1'b1;
               pixel_idx_d   = '0;
            end
         end
         CAPTURE: begin
            state_d = HOLD;
         end
         HOLD: begin
            // The engine's pointer lags one cycle, so ready is not looked at here.
            mem_we_d = 1'b1;
            state_d  = WRITE;
         end
         WRITE: begin
            if (bus.mem_ack) begin
               mem_we_d = 1'b0;
               state_d  = IDLE;
               if (pixel_idx_q == LAST_PIX) begin
                  pixel_idx_d  = '0;
                  bank_d       = ~bank_q;
                  frame_done_d = 1'b1;
               end else begin
                  pixel_idx_d = pixel_idx_q + ADDR_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         bank_q        <= 1'b0;
         pixel_idx_q   <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= 8'h00;
         mem_we_q      <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bank_q        <= bank_d;
         pixel_idx_q   <= pixel_idx_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_we_q      <= mem_we_d;
         frame_done_q  <= frame_done_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign bus.send_data    = (state_q == CAPTURE);
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.display_bank = ~bank_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.frame_error  = frame_error_q;

endmodule
